// File: rtl/sprite_bus_writer_if.sv
// Sprite descriptor memory write bus.
//   MW_o      : one-cycle write strobe per word
//   address_o : 30-bit word address (zero when MW_o=0)
//   data_o    : 32-bit write data (zero when MW_o=0)
//   busy_o    : write sequence in progress
// master = sprite_bus_writer, slave = memory write port / observer.
interface sprite_bus_if;
  logic        MW_o;
  logic [29:0] address_o;
  logic [31:0] data_o;
  logic        busy_o;

  modport master (output MW_o, output address_o, output data_o, output busy_o);
  modport slave  (input  MW_o, input  address_o, input  data_o, input  busy_o);
endinterface

// File: rtl/sprite_bus_writer.sv
// Sprite slot selector / enable writer.
// Two push-buttons select a sprite slot and toggle its enable bit; each toggle
// writes the slot's position word and enable word into the sprite descriptor
// table through the sprite_bus_if master port.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   btn_i          : async "next slot" button
//   btn_confirm_i  : async "toggle and commit" button
//   slot_o         : currently selected slot (registered)
//   bus            : MW_o / address_o / data_o / busy_o (registered)
// Build option: define SPRITE_WRITER_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES
// debouncer between each synchronizer and its edge detector.

// Button conditioning: synchronizer, optional debouncer, armed edge detector.
module sprite_btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic       sync1_q, sync2_q;
  logic [1:0] warm_q;
  logic       armed_q;
  logic       filt;
  logic       lvl_q, prev_q, pulse_q;

  // Two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Counts the cycles until sync2_q reflects the real pin after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warm_q <= 2'd0;
    else if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
  end

`ifdef SPRITE_WRITER_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] db_cnt_q;
  logic             db_level_q;

  // Accept a new level only after it differs from the current one for
  // DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (sync2_q == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q   <= '0;
      db_level_q <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  assign filt = db_level_q;
`else
  assign filt = sync2_q;
`endif

  // Rising-edge detector; only armed once the pin has been seen low after
  // reset, so a button held through reset does not fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      armed_q <= armed_q | ((warm_q == 2'd2) & ~sync2_q);
      lvl_q   <= filt;
      prev_q  <= lvl_q;
      pulse_q <= lvl_q & ~prev_q & armed_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

module sprite_bus_writer #(
  parameter logic [29:0] BASE_ADDR       = 30'h0000_0000,
  parameter int unsigned NUM_SLOTS       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned WRITE_GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_i,
  input  logic             btn_confirm_i,
  output logic [2:0]       slot_o,
  sprite_bus_if.master     bus
);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_chk_slots
    $error("NUM_SLOTS must be in 1..8");
  end
  if (WRITE_GAP > 15) begin : g_chk_gap
    $error("WRITE_GAP must be in 0..15");
  end

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);
  localparam logic [4:0] GAP_LEN   = 5'(WRITE_GAP);

  typedef enum logic [2:0] {IDLE, WR_POS, GAP0, WR_EN, DONE} state_t;

  logic        next_pulse, conf_pulse;
  state_t      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [2:0]  slot_q, slot_d;
  logic [7:0]  en_q, en_d;
  logic        mw_q, mw_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic [29:0] pos_addr;

  sprite_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_i),
    .pulse_o (next_pulse)
  );

  sprite_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_conf (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_confirm_i),
    .pulse_o (conf_pulse)
  );

  // Position word address for the latched slot (30-bit wrap)
  assign pos_addr = BASE_ADDR + {26'd0, slot_q, 1'b0};

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      slot_q  <= 3'd0;
      en_q    <= 8'd0;
      mw_q    <= 1'b0;
      addr_q  <= 30'd0;
      data_q  <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      slot_q  <= slot_d;
      en_q    <= en_d;
      mw_q    <= mw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, slot/enable updates, and next registered outputs
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    slot_d  = slot_q;
    en_d    = en_q;
    mw_d    = 1'b0;
    addr_d  = 30'd0;
    data_d  = 32'd0;

    case (state_q)
      IDLE: begin
        // Confirm wins over a same-cycle slot advance
        if (conf_pulse) begin
          en_d[slot_q] = ~en_q[slot_q];
          state_d      = WR_POS;
        end else if (next_pulse) begin
          slot_d = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
        end
      end
      WR_POS: begin
        gap_d   = 4'd0;
        state_d = (GAP_LEN == 5'd0) ? WR_EN : GAP0;
      end
      GAP0: begin
        if (5'(gap_q) + 5'd1 >= GAP_LEN) state_d = WR_EN;
        else gap_d = gap_q + 4'd1;
      end
      WR_EN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    case (state_d)
      WR_POS: begin
        mw_d   = 1'b1;
        addr_d = pos_addr;
        data_d = {16'(16'(slot_q) * 16'd80), 16'd200};
      end
      WR_EN: begin
        mw_d   = 1'b1;
        addr_d = pos_addr + 30'd1;
        data_d = {31'd0, en_d[slot_q]};
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign slot_o        = slot_q;
  assign bus.MW_o      = mw_q;
  assign bus.address_o = addr_q;
  assign bus.data_o    = data_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_sprite_bus_writer.sv
// Directed testbench for sprite_bus_writer (default parameters).
module tb_sprite_bus_writer;

`ifdef SPRITE_WRITER_DEBOUNCE_EN
  localparam int unsigned DB     = 16;
  localparam int          HOLD   = 24;
  localparam int          SETTLE = 40;
`else
  localparam int unsigned DB     = 500000;
  localparam int          HOLD   = 2;
  localparam int          SETTLE = 12;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       btn_confirm = 1'b0;
  logic [2:0] slot;

  sprite_bus_if bus ();

  sprite_bus_writer #(
    .BASE_ADDR       (30'h0000_0000),
    .NUM_SLOTS       (8),
    .DEBOUNCE_CYCLES (DB),
    .WRITE_GAP       (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_i         (btn),
    .btn_confirm_i (btn_confirm),
    .slot_o        (slot),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int press_cyc = 0;
  int busy_cnt = 0;
  int bad_idle = 0;
  logic [29:0] addr_log[$];
  logic [31:0] data_log[$];
  int          t_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer: records every write and any nonzero idle bus value
  always @(negedge clk) begin
    if (bus.MW_o === 1'b1) begin
      addr_log.push_back(bus.address_o);
      data_log.push_back(bus.data_o);
      t_log.push_back(cyc);
    end else if (bus.address_o !== 30'd0 || bus.data_o !== 32'd0) begin
      bad_idle++;
    end
    if (bus.busy_o === 1'b1) busy_cnt++;
  end

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
    t_log.delete();
    busy_cnt = 0;
  endtask

  task automatic press(input logic b, input logic c, input int hold);
    @(negedge clk);
    btn = b;
    btn_confirm = c;
    press_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    btn_confirm = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.MW_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mw got %b exp 0", bus.MW_o); end
    tests_run++; if (bus.address_o !== 30'd0) begin tests_failed++; $display("FAIL reset_addr got %h exp 0", bus.address_o); end
    tests_run++; if (bus.data_o !== 32'd0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", bus.data_o); end
    tests_run++; if (slot !== 3'd0) begin tests_failed++; $display("FAIL reset_slot got %0d exp 0", slot); end
    tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_write();
    clear_log();
    press(1'b0, 1'b1, HOLD);
    tests_run++; if (addr_log.size() !== 2) begin tests_failed++; $display("FAIL single_count got %0d exp 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      tests_run++; if (addr_log[0] !== 30'd0) begin tests_failed++; $display("FAIL single_addr0 got %h exp 0", addr_log[0]); end
      tests_run++; if (data_log[0] !== 32'h0000_00C8) begin tests_failed++; $display("FAIL single_data0 got %h exp 000000c8", data_log[0]); end
      tests_run++; if (addr_log[1] !== 30'd1) begin tests_failed++; $display("FAIL single_addr1 got %h exp 1", addr_log[1]); end
      tests_run++; if (data_log[1] !== 32'h0000_0001) begin tests_failed++; $display("FAIL single_data1 got %h exp 1", data_log[1]); end
      tests_run++; if (t_log[1] - t_log[0] !== 2) begin tests_failed++; $display("FAIL single_gap got %0d exp 2", t_log[1] - t_log[0]); end
`ifndef SPRITE_WRITER_DEBOUNCE_EN
      tests_run++; if (t_log[0] !== press_cyc + 4) begin tests_failed++; $display("FAIL single_latency got %0d exp %0d", t_log[0], press_cyc + 4); end
`endif
    end
    tests_run++; if (busy_cnt !== 4) begin tests_failed++; $display("FAIL single_busy got %0d exp 4", busy_cnt); end
  endtask

  task automatic test_slot_advance();
    logic [2:0] exp_slot;
    clear_log();
    exp_slot = 3'd0;
    for (int i = 0; i < 9; i++) begin
      press(1'b1, 1'b0, HOLD);
      exp_slot = (exp_slot == 3'd7) ? 3'd0 : exp_slot + 3'd1;
      tests_run++; if (slot !== exp_slot) begin tests_failed++; $display("FAIL advance_%0d got %0d exp %0d", i, slot, exp_slot); end
    end
    tests_run++; if (addr_log.size() !== 0) begin tests_failed++; $display("FAIL advance_nowrite got %0d exp 0", addr_log.size()); end
  endtask

  task automatic test_double_confirm();
    press(1'b1, 1'b0, HOLD);
    press(1'b1, 1'b0, HOLD);
    tests_run++; if (slot !== 3'd3) begin tests_failed++; $display("FAIL double_slot got %0d exp 3", slot); end
    clear_log();
    press(1'b0, 1'b1, HOLD);
    press(1'b0, 1'b1, HOLD);
    tests_run++; if (addr_log.size() !== 4) begin tests_failed++; $display("FAIL double_count got %0d exp 4", addr_log.size()); end
    if (addr_log.size() == 4) begin
      tests_run++; if (addr_log[0] !== 30'd6 || data_log[0] !== 32'h00F0_00C8) begin tests_failed++; $display("FAIL double_pos1 got %h/%h exp 6/00f000c8", addr_log[0], data_log[0]); end
      tests_run++; if (addr_log[1] !== 30'd7 || data_log[1] !== 32'd1) begin tests_failed++; $display("FAIL double_en1 got %h/%h exp 7/1", addr_log[1], data_log[1]); end
      tests_run++; if (addr_log[2] !== 30'd6 || data_log[2] !== 32'h00F0_00C8) begin tests_failed++; $display("FAIL double_pos2 got %h/%h exp 6/00f000c8", addr_log[2], data_log[2]); end
      tests_run++; if (addr_log[3] !== 30'd7 || data_log[3] !== 32'd0) begin tests_failed++; $display("FAIL double_en2 got %h/%h exp 7/0", addr_log[3], data_log[3]); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, HOLD);
    tests_run++; if (slot !== 3'd2) begin tests_failed++; $display("FAIL simul_pre_slot got %0d exp 2", slot); end
    clear_log();
`ifdef SPRITE_WRITER_DEBOUNCE_EN
    press(1'b1, 1'b1, HOLD);
`else
    // Both edges together, then a second next-slot edge lands mid-sequence
    @(negedge clk); btn = 1'b1; btn_confirm = 1'b1;
    @(negedge clk); btn = 1'b0; btn_confirm = 1'b0;
    @(negedge clk); btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (SETTLE) @(negedge clk);
`endif
    tests_run++; if (addr_log.size() !== 2) begin tests_failed++; $display("FAIL simul_count got %0d exp 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      tests_run++; if (addr_log[0] !== 30'd4 || data_log[0] !== 32'h00A0_00C8) begin tests_failed++; $display("FAIL simul_pos got %h/%h exp 4/00a000c8", addr_log[0], data_log[0]); end
      tests_run++; if (addr_log[1] !== 30'd5 || data_log[1] !== 32'd1) begin tests_failed++; $display("FAIL simul_en got %h/%h exp 5/1", addr_log[1], data_log[1]); end
    end
    tests_run++; if (slot !== 3'd2) begin tests_failed++; $display("FAIL simul_slot got %0d exp 2", slot); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_log();
    seen = 1'b0;
    @(negedge clk); btn_confirm = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == HOLD) btn_confirm = 1'b0;
      if (bus.MW_o === 1'b1) begin seen = 1'b1; break; end
    end
    btn_confirm = 1'b0;
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rstmid_timeout got %b exp 1", seen); end
    @(posedge clk); #1;
    tests_run++; if (bus.MW_o !== 1'b0 || bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_gap got mw=%b busy=%b exp mw=0 busy=1", bus.MW_o, bus.busy_o); end
    rst = 1'b1;
    #1;
    tests_run++; if (bus.MW_o !== 1'b0 || bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl got mw=%b busy=%b exp 0/0", bus.MW_o, bus.busy_o); end
    tests_run++; if (bus.address_o !== 30'd0 || bus.data_o !== 32'd0) begin tests_failed++; $display("FAIL rstmid_bus got %h/%h exp 0/0", bus.address_o, bus.data_o); end
    tests_run++; if (slot !== 3'd0) begin tests_failed++; $display("FAIL rstmid_slot got %0d exp 0", slot); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (SETTLE) @(negedge clk);
    tests_run++; if (addr_log.size() !== 1) begin tests_failed++; $display("FAIL rstmid_count got %0d exp 1", addr_log.size()); end
    if (addr_log.size() >= 1) begin
      tests_run++; if (addr_log[0] !== 30'd4) begin tests_failed++; $display("FAIL rstmid_addr got %h exp 4", addr_log[0]); end
    end
    // Enable bits cleared: slot 0 toggles from 0 back to 1
    clear_log();
    press(1'b0, 1'b1, HOLD);
    tests_run++; if (addr_log.size() !== 2) begin tests_failed++; $display("FAIL rstmid_after_count got %0d exp 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      tests_run++; if (addr_log[1] !== 30'd1 || data_log[1] !== 32'd1) begin tests_failed++; $display("FAIL rstmid_after_en got %h/%h exp 1/1", addr_log[1], data_log[1]); end
    end
  endtask

  task automatic test_held_across_reset();
    clear_log();
    @(negedge clk); btn_confirm = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HOLD + 20) @(negedge clk);
    btn_confirm = 1'b0;
    repeat (SETTLE) @(negedge clk);
    tests_run++; if (addr_log.size() !== 0) begin tests_failed++; $display("FAIL held_noedge got %0d exp 0", addr_log.size()); end
    press(1'b0, 1'b1, HOLD);
    tests_run++; if (addr_log.size() !== 2) begin tests_failed++; $display("FAIL held_repress got %0d exp 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      tests_run++; if (data_log[1] !== 32'd1) begin tests_failed++; $display("FAIL held_en got %h exp 1", data_log[1]); end
    end
  endtask

`ifdef SPRITE_WRITER_DEBOUNCE_EN
  task automatic test_glitch();
    clear_log();
    press(1'b0, 1'b1, 10);
    tests_run++; if (addr_log.size() !== 0) begin tests_failed++; $display("FAIL glitch_short got %0d exp 0", addr_log.size()); end
    press(1'b0, 1'b1, 30);
    tests_run++; if (addr_log.size() !== 2) begin tests_failed++; $display("FAIL glitch_long got %0d exp 2", addr_log.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_slot_advance();
    test_double_confirm();
    test_simultaneous();
    test_reset_mid();
    test_held_across_reset();
`ifdef SPRITE_WRITER_DEBOUNCE_EN
    test_glitch();
`endif
    tests_run++; if (bad_idle !== 0) begin tests_failed++; $display("FAIL idle_bus_zero got %0d exp 0", bad_idle); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
